// File: rtl/cla4_response_checker_if.sv
// cla4_response_checker_if: vector/response handshake bundle into the CLA checker
interface cla4_response_checker_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] sum;
  logic       cout;
  logic       g_g;
  logic       p_g;
  modport master (output in_valid, a, b, cin, sum, cout, g_g, p_g, input in_ready);
  modport slave  (input in_valid, a, b, cin, sum, cout, g_g, p_g, output in_ready);
endinterface

// File: rtl/cla4_response_checker.sv
// cla4_response_checker: checks 4-bit CLA responses against a golden model and tracks exhaustive coverage
module cla4_response_checker #(
  parameter int CNT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  cla4_response_checker_if.slave s,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [CNT_W-1:0]    vec_count,
  output logic [CNT_W-1:0]    err_count,
  output logic                first_err_valid,
  output logic [8:0]          first_err_vec,
  output logic [6:0]          first_err_got
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [511:0] cov;
  logic [9:0]   uniq;
  logic [8:0]   idx;
  logic [4:0]   s5;
  logic [3:0]   g, p;
  logic [6:0]   exp_resp, got;
  logic         mis, accept, fresh, clr;
  assign s.in_ready = state == RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  assign pass = done && err_count == '0;
  // golden CLA result and comparison against the applied response
  always_comb begin
    s5 = {1'b0, s.a} + {1'b0, s.b} + {4'b0, s.cin};
    g = s.a & s.b;
    p = s.a ^ s.b;
    exp_resp = {s5[4], g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]), &p, s5[3:0]};
    got = {s.cout, s.g_g, s.p_g, s.sum};
    idx = {s.cin, s.b, s.a};
    mis = exp_resp != got;
  end
  // session control: accept decode, session clear and next state
  always_comb begin
    accept = s.in_valid && state == RUN;
    fresh = !cov[idx];
    clr = start && state != RUN;
    nxt = state == RUN ? ((accept && fresh && uniq == 10'd511) ? DONE : RUN) : (start ? RUN : state);
  end
  // state, counters, coverage map and first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vec_count <= '0;
      err_count <= '0;
      first_err_valid <= 1'b0;
      first_err_vec <= '0;
      first_err_got <= '0;
      cov <= '0;
      uniq <= '0;
    end else begin
      state <= nxt;
      if (clr) begin
        vec_count <= '0;
        err_count <= '0;
        first_err_valid <= 1'b0;
        first_err_vec <= '0;
        first_err_got <= '0;
        cov <= '0;
        uniq <= '0;
      end else if (accept) begin
        vec_count <= &vec_count ? vec_count : vec_count + CNT_W'(1);
        if (mis) err_count <= &err_count ? err_count : err_count + CNT_W'(1);
        if (mis && !first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec <= idx;
          first_err_got <= got;
        end
        if (fresh) begin
          cov[idx] <= 1'b1;
          uniq <= uniq + 10'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_cla4_response_checker.sv
// tb_cla4_response_checker: directed table and sequence checks for the CLA response checker
module tb_cla4_response_checker;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic busy, done, pass, fev;
  logic [9:0] vec_count, err_count;
  logic [8:0] fvec;
  logic [6:0] fgot;
  logic busy2, done2, pass2, fev2;
  logic [3:0] vec_count2, err_count2;
  logic [8:0] fvec2;
  logic [6:0] fgot2;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [8:0] v;
    logic [6:0] resp;
    int         e_err;
    logic       e_fev;
    logic [8:0] e_fvec;
    logic [6:0] e_fgot;
  } row_t;
  row_t tbl [5];
  cla4_response_checker_if ifc ();
  cla4_response_checker_if ifc2 ();
  cla4_response_checker #(.CNT_W(10)) dut (
    .clk(clk), .rst(rst), .start(start), .s(ifc), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count), .first_err_valid(fev),
    .first_err_vec(fvec), .first_err_got(fgot)
  );
  cla4_response_checker #(.CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .s(ifc2), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec_count2), .err_count(err_count2), .first_err_valid(fev2),
    .first_err_vec(fvec2), .first_err_got(fgot2)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] gold(input logic [8:0] v);
    int s, ab;
    ab = int'(v[3:0]) + int'(v[7:4]);
    s = ab + int'(v[8]);
    return {s > 15, ab > 15, (v[3:0] ^ v[7:4]) == 4'hF, 4'(s)};
  endfunction
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, got, exp);
    end
  endtask
  task automatic send(input logic [8:0] v, input logic [6:0] resp);
    {ifc.cin, ifc.b, ifc.a} = v;
    {ifc.cout, ifc.g_g, ifc.p_g, ifc.sum} = resp;
    ifc.in_valid = 1'b1;
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask
  task automatic sweep(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      if (i == hi) chk("pre_done", done, 0);
      send(9'(i), gold(9'(i)));
    end
  endtask
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_in_ready"}, ifc.in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_vec_count"}, vec_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_fev"}, fev, 0);
    chk({tag, "_fvec"}, fvec, 0);
    chk({tag, "_fgot"}, fgot, 0);
  endtask
  initial begin
    tbl[0] = '{9'h01F, 7'h60, 0, 1'b0, 9'h000, 7'h00};
    tbl[1] = '{9'h01F, 7'h40, 1, 1'b1, 9'h01F, 7'h40};
    tbl[2] = '{9'h1A5, 7'h50, 1, 1'b1, 9'h01F, 7'h40};
    tbl[3] = '{9'h1A5, 7'h51, 2, 1'b1, 9'h01F, 7'h40};
    tbl[4] = '{9'h033, 7'h06, 2, 1'b1, 9'h01F, 7'h40};
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    ifc.in_valid = 1'b0; ifc.a = '0; ifc.b = '0; ifc.cin = 1'b0;
    ifc.sum = '0; ifc.cout = 1'b0; ifc.g_g = 1'b0; ifc.p_g = 1'b0;
    ifc2.in_valid = 1'b0; ifc2.a = '0; ifc2.b = '0; ifc2.cin = 1'b0;
    ifc2.sum = '0; ifc2.cout = 1'b0; ifc2.g_g = 1'b0; ifc2.p_g = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset");
    rst = 1'b0;
    pulse_start();
    chk("run_busy", busy, 1);
    chk("run_in_ready", ifc.in_ready, 1);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].v, tbl[i].resp);
      chk($sformatf("tbl%0d_vec_count", i), vec_count, i + 1);
      chk($sformatf("tbl%0d_err_count", i), err_count, tbl[i].e_err);
      chk($sformatf("tbl%0d_fev", i), fev, tbl[i].e_fev);
      chk($sformatf("tbl%0d_fvec", i), fvec, tbl[i].e_fvec);
      chk($sformatf("tbl%0d_fgot", i), fgot, tbl[i].e_fgot);
      chk($sformatf("tbl%0d_done", i), done, 0);
    end
    pulse_start();
    chk("start_in_run_vec", vec_count, 5);
    chk("start_in_run_err", err_count, 2);
    chk("start_in_run_busy", busy, 1);
    sweep(0, 511);
    chk("fail_done", done, 1);
    chk("fail_pass", pass, 0);
    chk("fail_vec_count", vec_count, 517);
    chk("fail_err_count", err_count, 2);
    chk("fail_fvec", fvec, 9'h01F);
    send(9'h000, 7'h7F);
    chk("frozen_vec_count", vec_count, 517);
    chk("frozen_err_count", err_count, 2);
    chk("frozen_in_ready", ifc.in_ready, 0);
    pulse_start();
    chk("restart_vec_count", vec_count, 0);
    chk("restart_err_count", err_count, 0);
    chk("restart_fev", fev, 0);
    chk("restart_busy", busy, 1);
    for (int k = 0; k < 3; k++) begin
      send(9'h000, gold(9'h000));
      repeat (4) @(negedge clk);
    end
    chk("dup_vec_count", vec_count, 3);
    chk("dup_done", done, 0);
    sweep(1, 511);
    chk("dup_sweep_done", done, 1);
    chk("dup_sweep_pass", pass, 1);
    chk("dup_sweep_vec_count", vec_count, 514);
    pulse_start();
    for (int i = 0; i < 100; i++) send(9'(i), i == 7 ? ~gold(9'(i)) : gold(9'(i)));
    chk("mid_vec_count", vec_count, 100);
    chk("mid_fev", fev, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset("mid_rst");
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_in_ready", ifc.in_ready, 0);
    pulse_start();
    sweep(0, 511);
    chk("clean_done", done, 1);
    chk("clean_pass", pass, 1);
    chk("clean_vec_count", vec_count, 512);
    chk("clean_err_count", err_count, 0);
    chk("clean_fev", fev, 0);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    {ifc2.cin, ifc2.b, ifc2.a} = 9'h000;
    {ifc2.cout, ifc2.g_g, ifc2.p_g, ifc2.sum} = 7'h01;
    ifc2.in_valid = 1'b1;
    repeat (20) @(negedge clk);
    ifc2.in_valid = 1'b0;
    chk("sat_vec_count", vec_count2, 15);
    chk("sat_err_count", err_count2, 15);
    chk("sat_fev", fev2, 1);
    chk("sat_done", done2, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla4_response_checker.md
Name: cla4_response_checker

Overview:
- Sequential self-checking sink for the 4-bit carry-lookahead adder. It accepts one applied vector per handshake, together with the DUT response: {a, b, cin} plus {sum, cout, g_g, p_g}.
- Recomputes the golden result internally, counts mismatches, and latches the first failing vector.
- Tracks coverage of all 512 {cin,b,a} combinations and declares pass/fail once coverage is complete.
- Sits on the consuming end of the exhaustive CLA stimulus stream, in both simulation and on-board BIST.

Parameters:
- CNT_W, 10, width of vec_count and err_count; both counters saturate at 2^CNT_W-1.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a checking session
- in_valid  in  1  vector/response pair present
- in_ready  out  1  checker accepts a pair this cycle
- a  in  4  applied operand A
- b  in  4  applied operand B
- cin  in  1  applied carry-in
- sum  in  4  DUT sum
- cout  in  1  DUT carry-out
- g_g  in  1  DUT group generate
- p_g  in  1  DUT group propagate
- busy  out  1  session running
- done  out  1  session complete, held until next start or reset
- pass  out  1  valid while done; 1 iff err_count==0
- vec_count  out  CNT_W  accepted pairs, duplicates included
- err_count  out  CNT_W  mismatching pairs
- first_err_valid  out  1  first_err_* fields are meaningful
- first_err_vec  out  9  {cin,b,a} of the first mismatch
- first_err_got  out  7  {cout,g_g,p_g,sum} of the first mismatch

Behaviour:
- Reset: state IDLE. All of the following are 0: in_ready, busy, done, pass, vec_count, err_count, first_err_valid, first_err_vec, first_err_got, the 512-bit coverage map, and the unique counter. Reset mid-session aborts it immediately with no residual state.
- Golden model:
  - exp_sum = (a+b+cin)[3:0]; exp_cout = bit 4 of a 5-bit sum.
  - g_i = a_i&b_i; p_i = a_i^b_i.
  - exp_g_g = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - exp_p_g = p3&p2&p1&p0.
  - Mismatch if any of the 7 response bits differs.
- FSM states:
  - IDLE: in_ready=0. start -> RUN, clearing the counters, the coverage map, and the first_err fields.
  - RUN: in_ready=1, busy=1. Accept = in_valid&in_ready.
    - On accept: vec_count+1 (saturating).
    - On mismatch: err_count+1 (saturating).
    - On the first mismatch of the session: latch first_err_vec/first_err_got and set first_err_valid. Later mismatches leave these fields unchanged.
    - Coverage: if bit {cin,b,a} of the map is clear, set it and increment the unique counter (10 bits).
    - start in RUN is ignored.
  - When the accept brings the unique counter to 512: next state DONE. That pair's check is included in the final counts.
  - DONE: in_ready=0, busy=0, done=1, pass=(err_count==0). Counts are frozen; in_valid is ignored. start -> RUN, with the same clear as from IDLE.
- Latency: counters, first_err_* and done reflect an accepted pair on the next rising edge. There is no combinational path from the data inputs to any output; only in_ready is decoded from state.
- Duplicate vectors are checked and counted, but do not advance coverage.
- Saturation: the counters hold at 2^CNT_W-1 and do not wrap.
- Simultaneous rst and start: rst wins, and the state is IDLE.

Test Plan:
- Reset, then start, then all 512 vectors with correct golden responses -> done=1 the cycle after the 512th accept; pass=1, vec_count=512, err_count=0, first_err_valid=0.
- Single vector a=0xF, b=0x1, cin=0 with response sum=0, cout=1, g_g=1, p_g=0 -> no error. Same vector with g_g=0 -> err_count=1, first_err_vec=0x01F, first_err_got=7'b1_0_0_0000.
- a=0x5, b=0xA, cin=1 with sum=0, cout=1, g_g=0, p_g=1 -> no error. A second mismatch later in the session must leave first_err_* unchanged.
- Duplicates and stalls: the same vector is sent 3 times, and in_valid is held low for several cycles -> vec_count=3, coverage advances by 1, done does not assert; then the remaining 511 vectors -> done=1.
- rst asserted mid-session after 100 vectors -> all outputs return to reset values next cycle; a new start plus the full sweep produces a clean pass. start pulsed during RUN has no effect.
- Saturation with CNT_W=4: 20 mismatching duplicate pairs -> err_count and vec_count hold at 15.
